concat_seq_ctrl: RTL and testbench

Sequencer for the three-field concatenation datapath. It accepts operands a, b and c serially over one FIELD_W-bit valid/ready stream and drives them into the concat datapath. It registers the OUT_W-bit result and presents it on a valid/ready output. It sits between a narrow serial producer and any consumer of the packed result, and counts completed frames.

---
 rtl/concat_seq_ctrl_pkg.sv | 15 +
 rtl/concat_seq_ctrl_if.sv | 26 ++
 rtl/concat_seq_ctrl_field_concat_dp.sv | 16 +
 rtl/concat_seq_ctrl.sv | 89 ++++++++
 tb/tb_concat_seq_ctrl.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/concat_seq_ctrl_pkg.sv
// rtl/concat_seq_ctrl_pkg.sv - shared state encoding and default widths for concat_seq_ctrl
package concat_seq_ctrl_pkg;

  localparam int DEF_FIELD_W = 3;
  localparam int DEF_OUT_W   = 5;
  localparam int DEF_CNT_W   = 8;

  typedef enum logic [1:0] {
    S_A   = 2'd0,
    S_B   = 2'd1,
    S_C   = 2'd2,
    S_OUT = 2'd3
  } state_t;

endpackage

// File: rtl/concat_seq_ctrl_if.sv
// rtl/concat_seq_ctrl_if.sv - serial field input stream and packed result output stream
interface concat_seq_ctrl_if
  import concat_seq_ctrl_pkg::*;
#(
  parameter int FIELD_W = DEF_FIELD_W,
  parameter int OUT_W   = DEF_OUT_W
) ();

  logic [FIELD_W-1:0] in_data;
  logic               in_valid;
  logic               in_ready;
  logic [OUT_W-1:0]   out_y;
  logic               out_valid;
  logic               out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_y, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_y, out_valid
  );

endinterface

// File: rtl/concat_seq_ctrl_field_concat_dp.sv
// rtl/concat_seq_ctrl_field_concat_dp.sv - combinational {a,b,c} concat truncated to OUT_W
module field_concat_dp
  import concat_seq_ctrl_pkg::*;
#(
  parameter int FIELD_W = DEF_FIELD_W,
  parameter int OUT_W   = DEF_OUT_W
) (
  input  logic [FIELD_W-1:0] a,
  input  logic [FIELD_W-1:0] b,
  input  logic [FIELD_W-1:0] c,
  output logic [OUT_W-1:0]   y
);

  assign y = OUT_W'({a, b, c});

endmodule

// File: rtl/concat_seq_ctrl.sv
// rtl/concat_seq_ctrl.sv - serial a/b/c loader driving the concat datapath with a registered result
module concat_seq_ctrl
  import concat_seq_ctrl_pkg::*;
#(
  parameter int FIELD_W = DEF_FIELD_W,
  parameter int OUT_W   = DEF_OUT_W,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  concat_seq_ctrl_if.slave bus,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             busy
);

  state_t             state;
  logic [FIELD_W-1:0] a;
  logic [FIELD_W-1:0] b;
  logic [FIELD_W-1:0] c;
  logic [FIELD_W-1:0] c_in;
  logic [OUT_W-1:0]   cat_y;

  // The arriving c feeds the datapath directly so the result lands on the c edge.
  assign c_in = (state == S_C) ? bus.in_data : c;

  field_concat_dp #(
    .FIELD_W(FIELD_W),
    .OUT_W  (OUT_W)
  ) u_dp (
    .a(a),
    .b(b),
    .c(c_in),
    .y(cat_y)
  );

  assign bus.in_ready = (state != S_OUT);
  assign busy         = (state != S_A);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_A;
      a             <= '0;
      b             <= '0;
      c             <= '0;
      bus.out_y     <= '0;
      bus.out_valid <= 1'b0;
      frame_cnt     <= '0;
    end else begin
      case (state)
        S_A, S_B, S_C: begin
          if (flush) begin
            state <= S_A;
            a     <= '0;
            b     <= '0;
            c     <= '0;
          end else if (bus.in_valid) begin
            case (state)
              S_A: begin
                a     <= bus.in_data;
                state <= S_B;
              end
              S_B: begin
                b     <= bus.in_data;
                state <= S_C;
              end
              default: begin
                c             <= bus.in_data;
                bus.out_y     <= cat_y;
                bus.out_valid <= 1'b1;
                state         <= S_OUT;
              end
            endcase
          end
        end
        // flush is deliberately ignored here so a finished result is never lost
        S_OUT: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            frame_cnt     <= frame_cnt + 1'b1;
            state         <= S_A;
          end
        end
        default: state <= S_A;
      endcase
    end
  end

endmodule

// File: tb/tb_concat_seq_ctrl.sv
// tb/tb_concat_seq_ctrl.sv - directed and random checks of concat_seq_ctrl against a field-queue model
module tb_concat_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       flush;
  logic [7:0] fc;
  logic       bsy;
  logic [1:0] fc2;
  logic       bsy2;

  concat_seq_ctrl_if bus ();
  concat_seq_ctrl_if bus2 ();

  concat_seq_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .bus      (bus.slave),
    .frame_cnt(fc),
    .busy     (bsy)
  );

  concat_seq_ctrl #(.CNT_W(2)) dut2 (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .bus      (bus2.slave),
    .frame_cnt(fc2),
    .busy     (bsy2)
  );

  int checks = 0;
  int errors = 0;

  // Reference: fields collected so far, one pending result, consumed-frame count.
  int fq[$];
  bit pend = 1'b0;
  int res  = 0;
  int cnt  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit f, input bit v, input int d, input bit ordy);
    rst            = r;
    flush          = f;
    bus.in_valid   = v;
    bus.in_data    = d[2:0];
    bus.out_ready  = ordy;
    bus2.in_valid  = v;
    bus2.in_data   = d[2:0];
    bus2.out_ready = ordy;
    @(posedge clk);
    if (r) begin
      fq.delete();
      pend = 1'b0;
      res  = 0;
      cnt  = 0;
    end else if (pend) begin
      if (ordy) begin
        pend = 1'b0;
        cnt++;
      end
    end else if (f) begin
      fq.delete();
    end else if (v) begin
      fq.push_back(d & 7);
      if (fq.size() == 3) begin
        res  = (fq[0] * 64 + fq[1] * 8 + fq[2]) % 32;
        pend = 1'b1;
        fq.delete();
      end
    end
    #1;
    check("in_ready",   bus.in_ready,  !pend);
    check("out_valid",  bus.out_valid, pend);
    check("out_y",      bus.out_y,     res);
    check("busy",       bsy,           (pend || fq.size() != 0));
    check("frame_cnt",  fc,            cnt % 256);
    check("out_y2",     bus2.out_y,    res);
    check("frame_cnt2", fc2,           cnt % 4);
  endtask

  task automatic frame(input int x, input int y, input int z, input bit ordy);
    step(0, 0, 1, x, ordy);
    step(0, 0, 1, y, ordy);
    step(0, 0, 1, z, ordy);
  endtask

  initial begin
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1);
    check("reset_out_y", bus.out_y, 0);
    check("reset_cnt",   fc,        0);
    step(0, 0, 0, 0, 0);
    check("reset_in_ready", bus.in_ready, 1);

    frame(1, 6, 2, 1);
    check("first_y", bus.out_y, 5'b10010);
    step(0, 0, 0, 0, 1);
    check("first_cnt", fc, 1);

    step(1, 0, 0, 0, 0);
    frame(5, 6, 7, 1);
    check("b2b_y0", bus.out_y, 5'b10111);
    step(0, 0, 1, 1, 1);
    frame(1, 2, 3, 1);
    check("b2b_y1", bus.out_y, 5'b10011);
    step(0, 0, 1, 4, 1);
    frame(4, 5, 6, 1);
    check("b2b_y2", bus.out_y, 5'b01110);
    step(0, 0, 1, 7, 1);
    check("b2b_cnt", fc, 3);

    frame(1, 6, 2, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 7, 0);
    check("hold_y", bus.out_y, 5'b10010);
    step(0, 0, 1, 7, 1);
    step(0, 0, 1, 7, 1);
    check("hold_a_loaded", bsy, 1);
    step(0, 0, 1, 0, 1);
    step(0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 1);

    step(0, 0, 1, 5, 1);
    step(0, 0, 1, 6, 1);
    step(0, 1, 1, 3, 1);
    check("flush_idle", bsy, 0);
    frame(1, 2, 3, 1);
    check("flush_y", bus.out_y, 5'b10011);
    step(0, 0, 0, 0, 1);

    frame(1, 6, 2, 0);
    step(0, 1, 0, 0, 0);
    check("flush_out_kept", bus.out_valid, 1);
    step(0, 1, 0, 0, 1);
    check("flush_xfer_y", bus.out_y, 5'b10010);

    frame(1, 6, 2, 0);
    step(1, 0, 0, 0, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_cnt",       fc,            0);

    for (int k = 0; k < 5; k++) begin
      int exp_cnt2[5] = '{1, 2, 3, 0, 1};
      frame(k, k + 3, 7 - k, 1);
      step(0, 0, 0, 0, 1);
      check("wrap_cnt2", fc2, exp_cnt2[k]);
    end

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)),
           $urandom_range(0, 1) == 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
